fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/a_defines.sv | 39 +++
 rtl/npc_btb.sv | 114 +++++++++++
 rtl/fetch_pc_gen.sv | 103 ++++++++++
 tb/tb_fetch_pc_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_defines.sv
`default_nettype none
// ============================================================================
//  Module      : a_defines (package)
//  Description : Shared definitions for the fetch PC generator: the reset
//                fetch address, the branch-target-buffer entry layout, the
//                2-bit direction counter encoding and a start-slot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package a_defines;

    // Default reset fetch address.
    localparam logic [31:0] c_init_pc   = 32'h1c00_0000;

    // 2-bit saturating direction counter encoding. Bit 1 is the prediction.
    localparam logic [1:0]  c_cnt_snt   = 2'b00;   // strongly not-taken
    localparam logic [1:0]  c_cnt_wnt   = 2'b01;   // weakly not-taken
    localparam logic [1:0]  c_cnt_wt    = 2'b10;   // weakly taken
    localparam logic [1:0]  c_cnt_st    = 2'b11;   // strongly taken
    localparam logic [1:0]  c_cnt_alloc = c_cnt_wt;

    // BTB entry. Tag and slot are sized for the widest legal configuration
    // (FETCH_WIDTH up to 8); narrower configurations hold zeros in the
    // upper bits on both the stored and compared side.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [2:0]  slot;
        logic [31:0] target;
        logic [1:0]  cnt;
    } btb_entry_t;

    // Instruction slot of a pc inside its fetch block.
    function automatic logic [2:0] pc_slot(input logic [31:0] pc,
                                           input int unsigned fetch_width);
        return 3'((pc >> 2) & 32'(fetch_width - 1));
    endfunction

endpackage : a_defines
`default_nettype wire

// File: rtl/npc_btb.sv
`default_nettype none
// ============================================================================
//  Module      : npc_btb
//  Description : Direct-mapped branch target buffer with 2-bit counters.
//                Lookup is combinational on lookup_pc; updates are written
//                at the clock edge, so a same-cycle lookup sees old contents.
//  Ports       : clk, rst_n         - clock, synchronous active-low reset
//                lookup_pc          - registered fetch pc to predict for
//                pred_taken/slot/target - prediction for the lookup block
//                upd_valid/pc/target/taken - backend resolution update
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_btb
    import a_defines::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int BTB_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [2:0]  pred_slot,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int c_off_w    = $clog2(4 * FETCH_WIDTH);
    localparam int c_idx_bits = $clog2(BTB_DEPTH);
    localparam int c_idx_w    = (c_idx_bits > 0) ? c_idx_bits : 1;
    localparam int c_tag_lsb  = c_off_w + c_idx_bits;

    btb_entry_t r_mem [BTB_DEPTH];

    logic [c_idx_w-1:0] w_lk_idx;
    logic [31:0]        w_lk_tag;
    logic [2:0]         w_lk_slot;
    btb_entry_t         w_lk_entry;

    logic [c_idx_w-1:0] w_up_idx;
    logic [31:0]        w_up_tag;
    logic [2:0]         w_up_slot;
    btb_entry_t         w_up_entry;
    logic               w_up_hit;
    logic               w_wr_en;
    btb_entry_t         w_wr_entry;

    // ---------------- lookup ----------------
    assign w_lk_idx   = (BTB_DEPTH > 1) ? c_idx_w'(lookup_pc >> c_off_w) : '0;
    assign w_lk_tag   = lookup_pc >> c_tag_lsb;
    assign w_lk_slot  = pc_slot(lookup_pc, FETCH_WIDTH);
    assign w_lk_entry = r_mem[w_lk_idx];

    // A branch sitting before the entry slot has already been passed when
    // fetch enters mid-block, so it must not redirect this block.
    assign pred_taken  = w_lk_entry.valid
                      && (w_lk_entry.tag == w_lk_tag)
                      && (w_lk_entry.slot >= w_lk_slot)
                      && w_lk_entry.cnt[1];
    assign pred_slot   = w_lk_entry.slot;
    assign pred_target = w_lk_entry.target;

    // ---------------- update ----------------
    assign w_up_idx   = (BTB_DEPTH > 1) ? c_idx_w'(upd_pc >> c_off_w) : '0;
    assign w_up_tag   = upd_pc >> c_tag_lsb;
    assign w_up_slot  = pc_slot(upd_pc, FETCH_WIDTH);
    assign w_up_entry = r_mem[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_up_entry;
        if (upd_valid) begin
            if (w_up_hit) begin
                w_wr_en         = 1'b1;
                w_wr_entry.slot = w_up_slot;
                if (upd_taken) begin
                    w_wr_entry.target = upd_target;
                    if (w_up_entry.cnt != c_cnt_st) begin
                        w_wr_entry.cnt = w_up_entry.cnt + 2'd1;
                    end
                end else if (w_up_entry.cnt != c_cnt_snt) begin
                    w_wr_entry.cnt = w_up_entry.cnt - 2'd1;
                end
            end else if (upd_taken) begin
                // Only taken branches are worth a slot; a not-taken miss
                // would predict fall-through, which is the default anyway.
                w_wr_en           = 1'b1;
                w_wr_entry.valid  = 1'b1;
                w_wr_entry.tag    = w_up_tag;
                w_wr_entry.slot   = w_up_slot;
                w_wr_entry.target = upd_target;
                w_wr_entry.cnt    = c_cnt_alloc;
            end
        end
    end

    // Only the valid bits are reset; payload fields are don't-care until
    // an allocation writes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_mem[w_up_idx] <= w_wr_entry;
        end
    end

endmodule : npc_btb
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen
//  Description : Fetch PC generator. Holds the fetch pc, produces the
//                live-slot mask for the current fetch block and the next pc
//                from either the BTB prediction or the sequential block.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                g_flush, flush_pc   - global redirect
//                upd_*               - backend branch-resolution update
//                valid_o, ready_i    - fetch request handshake
//                pc_o, mask_o        - current fetch pc and live slots
//                pred_taken_o/slot_o/target_o - prediction for this block
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import a_defines::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter int          BTB_DEPTH   = 16,
    parameter logic [31:0] INIT_PC     = c_init_pc
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   g_flush,
    input  logic [31:0]            flush_pc,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic [31:0]            upd_target,
    input  logic                   upd_taken,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [31:0]            pc_o,
    output logic [FETCH_WIDTH-1:0] mask_o,
    output logic                   pred_taken_o,
    output logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] pred_slot_o,
    output logic [31:0]            pred_target_o
);

    localparam int c_slot_w    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int c_blk_bytes = 4 * FETCH_WIDTH;

    logic [31:0] r_pc;
    logic        r_valid;

    logic        w_pred_taken;
    logic [2:0]  w_pred_slot;
    logic [31:0] w_pred_target;
    logic [2:0]  w_start_slot;
    logic [31:0] w_base;
    logic [31:0] w_npc;
    logic        w_fire;

    npc_btb #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .BTB_DEPTH   (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc   (r_pc),
        .pred_taken  (w_pred_taken),
        .pred_slot   (w_pred_slot),
        .pred_target (w_pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken)
    );

    assign w_start_slot = pc_slot(r_pc, FETCH_WIDTH);
    assign w_base       = r_pc & ~32'(c_blk_bytes - 1);
    // Sequential next block; the add wraps naturally at 2^32.
    assign w_npc        = w_pred_taken ? w_pred_target
                                       : (w_base + 32'(c_blk_bytes));
    assign w_fire       = r_valid && ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= INIT_PC;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            if (g_flush) begin
                r_pc <= flush_pc;
            end else if (w_fire) begin
                r_pc <= w_npc;
            end
        end
    end

    // Slots before the entry point and after a predicted-taken branch are dead.
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_mask
        assign mask_o[i] = (3'(i) >= w_start_slot)
                        && (!w_pred_taken || (3'(i) <= w_pred_slot));
    end

    assign valid_o       = r_valid;
    assign pc_o          = r_pc;
    assign pred_taken_o  = w_pred_taken;
    assign pred_slot_o   = w_pred_slot[c_slot_w-1:0];
    assign pred_target_o = w_pred_target;

endmodule : fetch_pc_gen
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_gen
//  Description : Self-checking bench for fetch_pc_gen. A reference model of
//                the fetch pc and predictor table pushes the expected output
//                of each cycle into a queue; a monitor pops and compares on
//                every valid cycle. Directed scenarios are followed by
//                randomized redirects, updates, stalls and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam int          FW   = 2;
    localparam int          D    = 16;
    localparam int          SW   = (FW > 1) ? $clog2(FW) : 1;
    localparam int unsigned B    = 4 * FW;
    localparam logic [31:0] INIT = 32'h1c00_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          g_flush = 1'b0;
    logic [31:0]   flush_pc = '0;
    logic          upd_valid = 1'b0;
    logic [31:0]   upd_pc = '0;
    logic [31:0]   upd_target = '0;
    logic          upd_taken = 1'b0;
    logic          ready_i = 1'b1;
    logic          valid_o;
    logic [31:0]   pc_o;
    logic [FW-1:0] mask_o;
    logic          pred_taken_o;
    logic [SW-1:0] pred_slot_o;
    logic [31:0]   pred_target_o;

    fetch_pc_gen #(.FETCH_WIDTH(FW), .BTB_DEPTH(D), .INIT_PC(INIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .g_flush       (g_flush),
        .flush_pc      (flush_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .mask_o        (mask_o),
        .pred_taken_o  (pred_taken_o),
        .pred_slot_o   (pred_slot_o),
        .pred_target_o (pred_target_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]   pc;
        logic [FW-1:0] mask;
        bit            pt;
        int unsigned   slot;
        logic [31:0]   tgt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    bit          m_valid  = 1'b0;
    bit          seen_rst = 1'b0;
    logic [31:0] m_pc     = '0;
    bit          m_ok  [D];
    int unsigned m_tag [D];
    int unsigned m_slot[D];
    logic [31:0] m_tgt [D];
    int unsigned m_cnt [D];

    function automatic void predict(input logic [31:0] pc, output bit pt,
                                    output int unsigned slot, output logic [31:0] tgt);
        int unsigned s   = (pc % B) / 4;
        int unsigned idx = (pc / B) % D;
        int unsigned tag = pc / (B * D);
        pt   = m_ok[idx] && (m_tag[idx] == tag) && (m_slot[idx] >= s) && (m_cnt[idx] >= 2);
        slot = m_slot[idx];
        tgt  = m_tgt[idx];
    endfunction

    function automatic exp_t expect_of(input logic [31:0] pc);
        exp_t        e;
        int unsigned s = (pc % B) / 4;
        e.pc = pc;
        predict(pc, e.pt, e.slot, e.tgt);
        for (int i = 0; i < FW; i++) begin
            e.mask[i] = (i >= s) && (!e.pt || (i <= e.slot));
        end
        return e;
    endfunction

    always @(posedge clk) begin
        bit          pt;
        int unsigned ps;
        logic [31:0] ptgt;
        logic [31:0] npc;
        int unsigned idx, tag, s;
        if (!rst_n) begin
            seen_rst = 1'b1;
            m_valid  = 1'b0;
            m_pc     = INIT;
            for (int i = 0; i < D; i++) m_ok[i] = 1'b0;
        end else begin
            predict(m_pc, pt, ps, ptgt);
            npc = pt ? ptgt : (m_pc - (m_pc % B) + B);
            if (upd_valid) begin
                idx = (upd_pc / B) % D;
                tag = upd_pc / (B * D);
                s   = (upd_pc % B) / 4;
                if (m_ok[idx] && m_tag[idx] == tag) begin
                    m_slot[idx] = s;
                    if (upd_taken) begin
                        m_tgt[idx] = upd_target;
                        if (m_cnt[idx] < 3) m_cnt[idx] = m_cnt[idx] + 1;
                    end else if (m_cnt[idx] > 0) begin
                        m_cnt[idx] = m_cnt[idx] - 1;
                    end
                end else if (upd_taken) begin
                    m_ok[idx]   = 1'b1;
                    m_tag[idx]  = tag;
                    m_slot[idx] = s;
                    m_tgt[idx]  = upd_target;
                    m_cnt[idx]  = 2;
                end
            end
            if (g_flush)                 m_pc = flush_pc;
            else if (m_valid && ready_i) m_pc = npc;
            m_valid = 1'b1;
        end
        if (m_valid) q.push_back(expect_of(m_pc));
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (seen_rst) begin
            chk("valid_o", 32'(valid_o), 32'(m_valid));
            if (valid_o === 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: got valid_o=1 expected an entry in queue (t=%0t)", $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("sb_pc", pc_o, mon_e.pc);
                    chk("sb_mask", 32'(mask_o), 32'(mon_e.mask));
                    chk("sb_pred_taken", 32'(pred_taken_o), 32'(mon_e.pt));
                    if (mon_e.pt) begin
                        chk("sb_pred_slot", 32'(pred_slot_o), mon_e.slot);
                        chk("sb_pred_target", pred_target_o, mon_e.tgt);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 15) == 0) return 32'hffff_ff00 + ($urandom_range(0, 63) << 2);
        return 32'h1c00_0000 + ($urandom_range(0, 255) << 2);
    endfunction

    initial begin
        // Reset, then sequential fetch.
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_valid", 32'(valid_o), 32'd1);
        chk("init_pc", pc_o, 32'h1c00_0000);
        chk("init_mask", 32'(mask_o), 32'h3);
        chk("init_pt", 32'(pred_taken_o), 32'd0);
        @(negedge clk);
        chk("seq_pc1", pc_o, 32'h1c00_0008);
        @(negedge clk);
        chk("seq_pc2", pc_o, 32'h1c00_0010);

        // Redirect into the middle of a block.
        g_flush = 1'b1; flush_pc = 32'h1c00_0104;
        @(negedge clk);
        g_flush = 1'b0;
        chk("flush_pc", pc_o, 32'h1c00_0104);
        chk("flush_mask", 32'(mask_o), 32'h2);
        @(negedge clk);
        chk("flush_next", pc_o, 32'h1c00_0108);

        // Allocate a taken branch in the same cycle as a flush back onto it.
        upd_valid = 1'b1; upd_pc = 32'h1c00_0000; upd_target = 32'h1c00_0040; upd_taken = 1'b1;
        g_flush = 1'b1; flush_pc = 32'h1c00_0000; ready_i = 1'b0;
        @(negedge clk);
        upd_valid = 1'b0; g_flush = 1'b0;
        chk("alloc_pt", 32'(pred_taken_o), 32'd1);
        chk("alloc_slot", 32'(pred_slot_o), 32'd0);
        chk("alloc_mask", 32'(mask_o), 32'h1);
        chk("alloc_tgt", pred_target_o, 32'h1c00_0040);
        ready_i = 1'b1;
        @(negedge clk);
        chk("pred_npc", pc_o, 32'h1c00_0040);

        // Two not-taken updates: 10 -> 01 -> 00.
        upd_valid = 1'b1; upd_taken = 1'b0; upd_pc = 32'h1c00_0000;
        g_flush = 1'b1; flush_pc = 32'h1c00_0000;
        @(negedge clk);
        chk("nt1_pt", 32'(pred_taken_o), 32'd0);
        @(negedge clk);
        upd_valid = 1'b0; g_flush = 1'b0;
        chk("nt2_pt", 32'(pred_taken_o), 32'd0);
        chk("nt2_mask", 32'(mask_o), 32'h3);
        @(negedge clk);
        chk("nt_npc", pc_o, 32'h1c00_0008);

        // Stall holds, flush during stall still redirects.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", pc_o, 32'h1c00_0008);
            chk("stall_mask", 32'(mask_o), 32'h3);
        end
        g_flush = 1'b1; flush_pc = 32'h1c00_0200;
        @(negedge clk);
        g_flush = 1'b0; ready_i = 1'b1;
        chk("stall_flush_pc", pc_o, 32'h1c00_0200);

        // Wrap at the top of the address space.
        g_flush = 1'b1; flush_pc = 32'hffff_fff8;
        @(negedge clk);
        g_flush = 1'b0;
        chk("top_pc", pc_o, 32'hffff_fff8);
        chk("top_pt", 32'(pred_taken_o), 32'd0);
        @(negedge clk);
        chk("wrap_pc", pc_o, 32'h0000_0000);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            ready_i    = ($urandom_range(0, 3) != 0);
            g_flush    = ($urandom_range(0, 7) == 0);
            flush_pc   = rnd_addr();
            upd_valid  = ($urandom_range(0, 2) == 0);
            upd_pc     = rnd_addr();
            upd_target = rnd_addr();
            upd_taken  = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; g_flush = 1'b0; upd_valid = 1'b0; ready_i = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_fetch_pc_gen
`default_nettype wire
